// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; result lands after a fixed per-class latency.
// Optional accumulate ops (MADD/MADDU/MSUB/MSUBU) are built only when MDU_MADD_EN is defined.
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e             state_q;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] pend_q, pend_d;
    logic               busy_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               run_d;

    logic [2*WIDTH-1:0] sa, sb, ua, ub, prod_s, prod_u;
    logic [WIDTH-1:0]   dvd, dvs, uq, ur, q, r;
    logic               sdiv;

    assign sa     = {{WIDTH{a[WIDTH-1]}}, a};
    assign sb     = {{WIDTH{b[WIDTH-1]}}, b};
    assign ua     = {{WIDTH{1'b0}}, a};
    assign ub     = {{WIDTH{1'b0}}, b};
    // sign-extended operands give the signed product modulo 2^(2*WIDTH)
    assign prod_s = sa * sb;
    assign prod_u = ua * ub;

    // one unsigned divider; signed division works on magnitudes, so MIN/-1 needs no special case
    assign sdiv = (op == 4'd3);
    assign dvd  = (sdiv && a[WIDTH-1]) ? -a : a;
    assign dvs  = (sdiv && b[WIDTH-1]) ? -b : b;
    assign uq   = (dvs == '0) ? '0 : dvd / dvs;
    assign ur   = (dvs == '0) ? '0 : dvd % dvs;
    assign q    = (sdiv && (a[WIDTH-1] ^ b[WIDTH-1])) ? -uq : uq;
    assign r    = (sdiv && a[WIDTH-1]) ? -ur : ur;

    always_comb begin
        pend_d = {hi_q, lo_q};
        cnt_d  = '0;
        run_d  = 1'b0;
        unique case (1'b1)
            (op == 4'd1): begin
                pend_d = prod_s;
                cnt_d  = CW'(MULT_CYCLES);
                run_d  = 1'b1;
            end
            (op == 4'd2): begin
                pend_d = prod_u;
                cnt_d  = CW'(MULT_CYCLES);
                run_d  = 1'b1;
            end
            (op == 4'd3),
            (op == 4'd4): begin
                if (b != '0) pend_d = {r, q};
                cnt_d = CW'(DIV_CYCLES);
                run_d = 1'b1;
            end
`ifdef MDU_MADD_EN
            (op[3:2] == 2'b10): begin
                if (op[1])
                    pend_d = {hi_q, lo_q} - (op[0] ? prod_u : prod_s);
                else
                    pend_d = {hi_q, lo_q} + (op[0] ? prod_u : prod_s);
                cnt_d = CW'(MULT_CYCLES);
                run_d = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && !flush) begin
                        if (run_d) begin
                            pend_q  <= pend_d;
                            cnt_q   <= cnt_d;
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end else if (op == 4'd5) begin
                            hi_q <= a;
                        end else if (op == 4'd6) begin
                            lo_q <= a;
                        end
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        hi_q    <= pend_q[2*WIDTH-1:WIDTH];
                        lo_q    <= pend_q[WIDTH-1:0];
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: driver pushes timed expectations, monitor checks them.
// Works with and without MDU_MADD_EN.
module tb_mdu_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic [31:0] hi, lo;

    mdu_unit #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          at;
        logic        bz;
        logic [31:0] h;
        logic [31:0] l;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc = 0;
    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial forever begin
        exp_t e;
        @(negedge clk);
        while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
            e = sb_q.pop_front();
            if (e.at < cyc) begin
                nvec++;
                nerr++;
                $display("FAIL %s: check missed at %0d expected cycle %0d", e.tag, cyc, e.at);
            end else begin
                chk({e.tag, ".busy"}, {31'b0, busy}, {31'b0, e.bz});
                chk({e.tag, ".hi"}, hi, e.h);
                chk({e.tag, ".lo"}, lo, e.l);
            end
        end
    end

    function automatic exp_t mk(int at, logic bz, logic [63:0] v, string tag);
        exp_t e;
        e.at  = at;
        e.bz  = bz;
        e.h   = v[63:32];
        e.l   = v[31:0];
        e.tag = tag;
        return e;
    endfunction

    // poke: drive MTHI, MULT and flush while RUN; rst_at>0: reset in that busy cycle
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit fl, input bit poke, input int rst_at, input string tag);
        int          n, k;
        longint      sx, sy, lq, lr;
        logic [63:0] old, res, p;
        n   = 0;
        old = {mhi, mlo};
        res = old;
        sx  = longint'(int'(x));
        sy  = longint'(int'(y));
        if (!fl) begin
            case (o)
                4'd1: begin n = MC; res = 64'(sx * sy); end
                4'd2: begin n = MC; res = {32'b0, x} * {32'b0, y}; end
                4'd3: begin
                    n = DC;
                    if (y != 0) begin
                        lq  = sx / sy;
                        lr  = sx % sy;
                        res = {lr[31:0], lq[31:0]};
                    end
                end
                4'd4: begin n = DC; if (y != 0) res = {x % y, x / y}; end
                4'd5: res[63:32] = x;
                4'd6: res[31:0] = x;
`ifdef MDU_MADD_EN
                4'd8, 4'd9, 4'd10, 4'd11: begin
                    n   = MC;
                    p   = o[0] ? {32'b0, x} * {32'b0, y} : 64'(sx * sy);
                    res = o[1] ? old - p : old + p;
                end
`endif
                default: ;
            endcase
        end
        k = cyc;
        if (n == 0) begin
            sb_q.push_back(mk(k + 1, 1'b0, res, tag));
        end else begin
            sb_q.push_back(mk(k + 1, 1'b1, old, {tag, ".first"}));
            sb_q.push_back(mk(k + n, 1'b1, old, {tag, ".last"}));
            sb_q.push_back(mk(k + n + 1, 1'b0, res, {tag, ".done"}));
        end
        {mhi, mlo} = res;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        flush = fl;
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        op    = 4'd0;
        for (int i = 0; i < n; i++) begin
            if (rst_at > 0 && i == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk({tag, ".rst_busy"}, {31'b0, busy}, 32'd0);
                chk({tag, ".rst_hi"}, hi, 32'd0);
                chk({tag, ".rst_lo"}, lo, 32'd0);
                sb_q.delete();
                mhi = '0;
                mlo = '0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                break;
            end
            if (poke && i == 1) begin start = 1'b1; op = 4'd5; a = $urandom; end
            if (poke && i == 2) begin start = 1'b1; op = 4'd1; a = $urandom; b = $urandom; end
            if (poke && i == 3) flush = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            flush = 1'b0;
            op    = 4'd0;
        end
    endtask

    initial begin
        logic [3:0]  o;
        logic [31:0] x, y;
        logic [3:0]  ops [14] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 15};
        #2;
        chk("reset.busy", {31'b0, busy}, 32'd0);
        chk("reset.hi", hi, 32'd0);
        chk("reset.lo", lo, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        issue(4'd1, 32'hFFFF_FFFF, 32'd2, 0, 0, 0, "mult");
        issue(4'd2, 32'hFFFF_FFFF, 32'd2, 0, 0, 0, "multu");
        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, "div_neg");
        issue(4'd4, 32'd7, 32'd2, 0, 0, 0, "divu");
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, "div_ovf");
        issue(4'd5, 32'h1234, 32'd0, 0, 0, 0, "mthi");
        issue(4'd6, 32'h5678, 32'd0, 0, 0, 0, "mtlo");
        issue(4'd3, 32'd99, 32'd0, 0, 0, 0, "div_by0");
        issue(4'd4, 32'd99, 32'd0, 0, 0, 0, "divu_by0");
        issue(4'd1, 32'd3, 32'd4, 1, 0, 0, "mult_flush");
        issue(4'd4, 32'd1000, 32'd7, 0, 1, 0, "div_poke");
        issue(4'd3, 32'd50, 32'd3, 0, 0, 2, "div_rst");
        issue(4'd1, 32'd6, 32'd7, 0, 0, 0, "mult_after_rst");
        issue(4'd5, 32'd0, 32'd0, 0, 0, 0, "mthi0");
        issue(4'd6, 32'd1, 32'd0, 0, 0, 0, "mtlo1");
        issue(4'd8, 32'd3, 32'd4, 0, 0, 0, "madd");
        issue(4'd11, 32'd1, 32'd14, 0, 0, 0, "msubu");
        issue(4'd13, 32'd5, 32'd5, 0, 0, 0, "undef");

        for (int i = 0; i < 60; i++) begin
            o = ops[$urandom_range(0, 13)];
            x = $urandom;
            case ($urandom_range(0, 5))
                0: y = 32'd0;
                1: y = 32'hFFFF_FFFF;
                2: y = $urandom_range(1, 9);
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
            issue(o, x, y, ($urandom_range(0, 7) == 0), 0, 0, $sformatf("rnd%0d_op%0d", i, o));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drain", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
